// File: rtl/branch_resolve_pkg.sv
// Shared CPU constants and pipeline register layouts used by the branch-resolve slice.
package branch_resolve_pkg;

  localparam logic [31:0] INSN_INC = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
  } idex_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Predictor-update bus from the EX-stage resolver to the branch predictor.
interface branch_resolve_if;
  // bp_update is a single-cycle strobe with no back-pressure: the predictor must
  // accept every update; bp_taken/bp_pc/bp_target are meaningful only while it is high.
  logic        bp_update;
  logic        bp_taken;
  logic [31:0] bp_pc;
  logic [31:0] bp_target;

  modport master (output bp_update, bp_taken, bp_pc, bp_target);
  modport slave  (input  bp_update, bp_taken, bp_pc, bp_target);
endinterface

// File: rtl/branch_resolve_target_calc.sv
// Combinational EX-stage datapath: control-flow target, taken decision and actual next PC.
module branch_target_calc
  import branch_resolve_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        bcond,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] next_pc
);

  logic [31:0] jalr_sum;

  assign jalr_sum = rs1 + imm;
  // jalr targets always drop bit 0 so the result is halfword aligned
  assign target   = is_jalr ? {jalr_sum[31:1], 1'b0} : pc + imm;
  assign taken    = is_jal | is_jalr | (is_branch & bcond);
  assign next_pc  = taken ? target : pc + INSN_INC;

endmodule

// File: rtl/branch_resolve.sv
// IF/ID and ID/EX tracking of predicted PCs, EX-stage mispredict detection,
// predictor update bus and saturating performance counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [31:0]             if_pc,
  input  logic [31:0]             if_predicted_pc,
  input  logic                    id_is_branch,
  input  logic                    id_is_jal,
  input  logic                    id_is_jalr,
  input  logic                    ex_bcond,
  input  logic [31:0]             ex_imm,
  input  logic [31:0]             ex_rs1,
  branch_resolve_if.master        bp,
  output logic                    flush,
  output logic [31:0]             redirect_pc,
  output logic [31:0]             ctl_count,
  output logic [31:0]             mispredict_count
);

  ifid_t       ifid_q;
  idex_t       idex_q;
  logic        taken;
  logic [31:0] target;
  logic [31:0] actual_pc;
  logic        upd;
  logic [31:0] ctl_cnt;
  logic [31:0] mis_cnt;

  branch_target_calc u_calc (
    .pc        (idex_q.pc),
    .is_branch (idex_q.is_branch),
    .is_jal    (idex_q.is_jal),
    .is_jalr   (idex_q.is_jalr),
    .bcond     (ex_bcond),
    .imm       (ex_imm),
    .rs1       (ex_rs1),
    .taken     (taken),
    .target    (target),
    .next_pc   (actual_pc)
  );

  // Any valid instruction can mispredict, including non-control-flow ones hit by aliasing.
  always_comb begin
    flush        = 1'b0;
    redirect_pc  = 32'h0;
    upd          = 1'b0;
    bp.bp_taken  = 1'b0;
    bp.bp_pc     = 32'h0;
    bp.bp_target = 32'h0;
    if (!reset && idex_q.valid) begin
      redirect_pc = actual_pc;
      flush       = (actual_pc != idex_q.pred_pc);
      if (idex_q.is_branch || idex_q.is_jal || idex_q.is_jalr) begin
        upd          = 1'b1;
        bp.bp_taken  = taken;
        bp.bp_pc     = idex_q.pc;
        bp.bp_target = target;
      end
    end
  end

  assign bp.bp_update = upd;

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= '{1'b0, PC_RESET, PC_RESET};
      idex_q <= '{1'b0, PC_RESET, PC_RESET, 1'b0, 1'b0, 1'b0};
    end else if (flush) begin
      ifid_q.valid <= 1'b0;
      idex_q.valid <= 1'b0;
    end else if (stall) begin
      idex_q.valid <= 1'b0;
    end else begin
      ifid_q <= '{1'b1, if_pc, if_predicted_pc};
      idex_q <= '{ifid_q.valid, ifid_q.pc, ifid_q.pred_pc,
                  id_is_branch, id_is_jal, id_is_jalr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_cnt <= 32'h0;
      mis_cnt <= 32'h0;
    end else begin
      if (upd)   ctl_cnt <= sat_inc(ctl_cnt);
      if (flush) mis_cnt <= sat_inc(mis_cnt);
    end
  end

  assign ctl_count        = ctl_cnt;
  assign mispredict_count = mis_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus random traffic against a pipeline-slot model.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] if_pc, if_predicted_pc;
  logic        id_is_branch, id_is_jal, id_is_jalr, ex_bcond;
  logic [31:0] ex_imm, ex_rs1;
  logic        flush;
  logic [31:0] redirect_pc, ctl_count, mispredict_count;

  branch_resolve_if bp_bus ();

  branch_resolve #(.PC_RESET(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .if_pc            (if_pc),
    .if_predicted_pc  (if_predicted_pc),
    .id_is_branch     (id_is_branch),
    .id_is_jal        (id_is_jal),
    .id_is_jalr       (id_is_jalr),
    .ex_bcond         (ex_bcond),
    .ex_imm           (ex_imm),
    .ex_rs1           (ex_rs1),
    .bp               (bp_bus.master),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .ctl_count        (ctl_count),
    .mispredict_count (mispredict_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model: two pipeline slots + counters ----------------
  logic        m_v1, m_v2, m_b, m_j, m_jr;
  logic [31:0] m_pc1, m_pred1, m_pc2, m_pred2, m_ctl, m_mis;
  logic [162:0] exp_q[$];
  logic [162:0] o, e;

  function automatic void model_eval(output logic f, output logic [31:0] rd,
                                     output logic u, output logic tk,
                                     output logic [31:0] bpc, output logic [31:0] tg);
    logic        tkn;
    logic [31:0] tgt, nxt;
    f = 1'b0; rd = 32'h0; u = 1'b0; tk = 1'b0; bpc = 32'h0; tg = 32'h0;
    if (reset || !m_v2) return;
    tkn = m_j || m_jr || (m_b && ex_bcond);
    tgt = m_jr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (m_pc2 + ex_imm);
    nxt = tkn ? tgt : (m_pc2 + 32'd4);
    rd  = nxt;
    f   = (nxt != m_pred2);
    if (m_b || m_j || m_jr) begin
      u = 1'b1; tk = tkn; bpc = m_pc2; tg = tgt;
    end
  endfunction

  task automatic expect_now();
    logic f, u, tk;
    logic [31:0] rd, bpc, tg;
    model_eval(f, rd, u, tk, bpc, tg);
    exp_q.push_back({f, rd, u, tk, bpc, tg, m_ctl, m_mis});
  endtask

  task automatic model_update();
    logic f, u, tk;
    logic [31:0] rd, bpc, tg;
    model_eval(f, rd, u, tk, bpc, tg);
    if (reset) begin
      m_v1 = 0; m_v2 = 0; m_b = 0; m_j = 0; m_jr = 0;
      m_pc1 = 0; m_pred1 = 0; m_pc2 = 0; m_pred2 = 0; m_ctl = 0; m_mis = 0;
    end else begin
      if (u && m_ctl != 32'hFFFF_FFFF) m_ctl = m_ctl + 1;
      if (f && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      if (f) begin
        m_v1 = 0; m_v2 = 0;
      end else if (stall) begin
        m_v2 = 0;
      end else begin
        m_v2 = m_v1; m_pc2 = m_pc1; m_pred2 = m_pred1;
        m_b = id_is_branch; m_j = id_is_jal; m_jr = id_is_jalr;
        m_v1 = 1; m_pc1 = if_pc; m_pred1 = if_predicted_pc;
      end
    end
  endtask

  function automatic logic [162:0] obs_vec();
    return {flush, redirect_pc, bp_bus.bp_update, bp_bus.bp_taken, bp_bus.bp_pc,
            bp_bus.bp_target, ctl_count, mispredict_count};
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_if(input logic [31:0] pc, input logic [31:0] pred);
    if_pc = pc; if_predicted_pc = pred;
  endtask

  task automatic drive_dec(input logic b, input logic j, input logic jr);
    id_is_branch = b; id_is_jal = j; id_is_jalr = jr;
  endtask

  task automatic drive_ex(input logic bc, input logic [31:0] imm, input logic [31:0] rs1);
    ex_bcond = bc; ex_imm = imm; ex_rs1 = rs1;
  endtask

  task automatic do_reset();
    reset = 1; stall = 0;
    drive_if(32'h0, 32'h4); drive_dec(0, 0, 0); drive_ex(0, 0, 0);
    step(); step();
    reset = 0;
  endtask

  // Places one instruction in ID/EX; caller must come straight from do_reset.
  task automatic load_insn(input logic [31:0] pc, input logic [31:0] pred,
                           input logic b, input logic j, input logic jr);
    stall = 0;
    drive_if(pc, pred); drive_dec(0, 0, 0); drive_ex(0, 0, 0);
    step();
    drive_if(pred, pred + 32'd4); drive_dec(b, j, jr);
    step();
    drive_dec(0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; stall = 1;
    drive_if($urandom, $urandom); drive_dec(1, 0, 0); drive_ex(1, $urandom, $urandom);
    step(); step();
    #1;
    expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_vec obs=%h exp=%h", o, e); end
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_zero obs=%h exp=0", o); end
    reset = 0;
  endtask

  task automatic test_branch_taken();
    do_reset();
    load_insn(32'h100, 32'h120, 1, 0, 0);
    drive_ex(1, 32'h20, 32'h0);
    #1;
    expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL taken_vec obs=%h exp=%h", o, e); end
    checks++;
    if (flush !== 1'b0 || bp_bus.bp_update !== 1'b1 || bp_bus.bp_taken !== 1'b1 ||
        bp_bus.bp_target !== 32'h120 || bp_bus.bp_pc !== 32'h100) begin
      errors++;
      $display("FAIL taken_fields flush=%b upd=%b tk=%b tgt=%h pc=%h want 0 1 1 00000120 00000100",
               flush, bp_bus.bp_update, bp_bus.bp_taken, bp_bus.bp_target, bp_bus.bp_pc);
    end
    step(); #1;
    checks++;
    if (ctl_count !== 32'd1) begin errors++; $display("FAIL taken_ctl got=%0d want=1", ctl_count); end
  endtask

  task automatic test_branch_not_taken();
    do_reset();
    load_insn(32'h100, 32'h120, 1, 0, 0);
    drive_ex(0, 32'h20, 32'h0);
    #1;
    expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL nt_vec obs=%h exp=%h", o, e); end
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h104 || bp_bus.bp_taken !== 1'b0 || bp_bus.bp_update !== 1'b1) begin
      errors++;
      $display("FAIL nt_fields flush=%b rd=%h tk=%b upd=%b want 1 00000104 0 1",
               flush, redirect_pc, bp_bus.bp_taken, bp_bus.bp_update);
    end
    step(); #1;
    checks++;
    if (dut.ifid_q.valid !== 1'b0 || dut.idex_q.valid !== 1'b0 || mispredict_count !== 32'd1) begin
      errors++;
      $display("FAIL nt_after ifid_v=%b idex_v=%b mis=%0d want 0 0 1",
               dut.ifid_q.valid, dut.idex_q.valid, mispredict_count);
    end
  endtask

  task automatic test_jalr();
    do_reset();
    load_insn(32'h100, 32'h104, 0, 0, 1);
    drive_ex(0, 32'h10, 32'h2001);
    #1;
    expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL jalr_vec obs=%h exp=%h", o, e); end
    checks++;
    if (bp_bus.bp_target !== 32'h2010 || flush !== 1'b1 || redirect_pc !== 32'h2010) begin
      errors++;
      $display("FAIL jalr_fields tgt=%h flush=%b rd=%h want 00002010 1 00002010",
               bp_bus.bp_target, flush, redirect_pc);
    end
    step();
  endtask

  task automatic test_aliasing();
    do_reset();
    load_insn(32'h200, 32'h300, 0, 0, 0);
    drive_ex(1, $urandom, $urandom);
    #1;
    expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL alias_vec obs=%h exp=%h", o, e); end
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h204 || bp_bus.bp_update !== 1'b0) begin
      errors++;
      $display("FAIL alias_fields flush=%b rd=%h upd=%b want 1 00000204 0",
               flush, redirect_pc, bp_bus.bp_update);
    end
    step();
  endtask

  task automatic test_stall_flush();
    do_reset();
    load_insn(32'h100, 32'h120, 1, 0, 0);
    drive_ex(0, 32'h20, 32'h0);
    stall = 1;
    #1;
    expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL sf_vec obs=%h exp=%h", o, e); end
    step(); #1;
    checks++;
    if (dut.ifid_q.valid !== 1'b0 || dut.idex_q.valid !== 1'b0) begin
      errors++;
      $display("FAIL sf_valids ifid_v=%b idex_v=%b want 0 0", dut.ifid_q.valid, dut.idex_q.valid);
    end
    stall = 0;
    drive_if(32'h400, 32'h404);
    step();
    drive_if(32'h500, 32'h504); drive_dec(0, 1, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL stall_vec[%0d] obs=%h exp=%h", i, o, e); end
      checks++;
      if (dut.ifid_q.valid !== 1'b1 || dut.ifid_q.pc !== 32'h400 || dut.idex_q.valid !== 1'b0 ||
          flush !== 1'b0 || bp_bus.bp_update !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] ifid_v=%b ifid_pc=%h idex_v=%b flush=%b upd=%b want 1 00000400 0 0 0",
                 i, dut.ifid_q.valid, dut.ifid_q.pc, dut.idex_q.valid, flush, bp_bus.bp_update);
      end
      if (i < 2) step();
    end
    stall = 0; drive_dec(0, 0, 0);
    step(); #1;
    expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL unstall_vec obs=%h exp=%h", o, e); end
    checks++;
    if (redirect_pc !== 32'h404 || flush !== 1'b0) begin
      errors++; $display("FAIL unstall_rd rd=%h flush=%b want 00000404 0", redirect_pc, flush);
    end
    step();
  endtask

  task automatic test_random();
    int r;
    logic [31:0] pc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pc = 32'($urandom_range(0, 1023)) * 32'd4;
      r  = $urandom_range(0, 3);
      drive_if(pc, (r < 2) ? pc + 32'd4 : {$urandom_range(0, 4095), 2'b00});
      r  = $urandom_range(0, 3);
      drive_dec(r == 1, r == 2, r == 3);
      drive_ex($urandom_range(0, 1), 32'($urandom_range(0, 511)) - 32'd256, $urandom);
      stall = ($urandom_range(0, 99) < 15);
      #1;
      expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL random[%0d] obs=%h exp=%h", n, o, e); end
      step();
    end
    stall = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    #1 force dut.mis_cnt = 32'hFFFF_FFFE;
    #1 release dut.mis_cnt;
    m_mis = 32'hFFFF_FFFE;
    drive_if(32'h200, 32'h300); drive_dec(0, 0, 0); drive_ex(0, 0, 0); stall = 0;
    for (int n = 0; n < 10; n++) begin
      #1;
      expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL sat_vec[%0d] obs=%h exp=%h", n, o, e); end
      step();
    end
    #1;
    checks++;
    if (mispredict_count !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_final got=%h want=ffffffff", mispredict_count);
    end
    reset = 1;
    #1;
    expect_now(); o = obs_vec(); e = exp_q.pop_front(); checks++;
    if (o !== e) begin errors++; $display("FAIL sat_rst_comb obs=%h exp=%h", o, e); end
    step(); #1;
    checks++;
    if (obs_vec() !== '0) begin errors++; $display("FAIL sat_rst_zero obs=%h exp=0", obs_vec()); end
    reset = 0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    m_v1 = 0; m_v2 = 0; m_b = 0; m_j = 0; m_jr = 0;
    m_pc1 = 0; m_pred1 = 0; m_pc2 = 0; m_pred2 = 0; m_ctl = 0; m_mis = 0;
    test_reset();
    test_branch_taken();
    test_branch_not_taken();
    test_jalr();
    test_aliasing();
    test_stall_flush();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
